// File: rtl/cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : cmd_issuer
// Description : Host command FIFO feeding the control FSM one stable word per
//               capture strobe; substitutes NOP when empty or halted.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_issuer #(
    parameter int         DEPTH   = 4,
    parameter logic [6:0] NOP_CMD = 7'b0000111
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [6:0]               host_cmd,
    input  logic                     host_valid,
    output logic                     host_ready,
    input  logic                     datain_reg_en,
    input  logic                     invalid_data,
    input  logic                     halt_on_err,
    input  logic                     resume,
    output logic [6:0]               cmd_out,
    output logic                     cmd_is_nop,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               issued_count,
    output logic [7:0]               err_count,
    output logic [6:0]               err_cmd,
    output logic                     halted
);

    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam int                 c_LVL_W   = c_PTR_W + 1;
    localparam logic [c_LVL_W-1:0] c_FULL    = c_LVL_W'(DEPTH);
    localparam logic [c_LVL_W-1:0] c_LVL_ONE = c_LVL_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_halted;
    logic [6:0]           r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_LVL_W-1:0]   r_level;
    logic [6:0]           r_cmd_out;
    logic                 r_cmd_is_nop;
    logic [7:0]           r_issued_count;
    logic [7:0]           r_err_count;
    logic [6:0]           r_err_cmd;

    logic                 w_ready;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_err_halt;
    logic [c_LVL_W-1:0]   w_level_nxt;
    state_t               w_run_state;

    assign w_ready    = (r_level != c_FULL);
    assign w_push     = host_valid && w_ready;
    // Popping requires ACTIVE; the level guard only protects the read pointer.
    assign w_pop      = datain_reg_en && (r_state == ST_ACTIVE) && (r_level != '0);
    assign w_err_halt = invalid_data && halt_on_err;

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + c_LVL_ONE;
            2'b01:   w_level_nxt = r_level - c_LVL_ONE;
            default: w_level_nxt = r_level;
        endcase
    end

    assign w_run_state = (w_level_nxt != '0) ? ST_ACTIVE : ST_EMPTY;

    // An error outranks resume, so a same-cycle error keeps the block halted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_EMPTY;
            r_halted <= 1'b0;
        end else if (w_err_halt) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
        end else if ((r_state == ST_HALTED) && !resume) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
        end else begin
            r_state  <= w_run_state;
            r_halted <= 1'b0;
        end
    end

    // Storage needs no reset: occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= host_cmd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_level <= w_level_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cmd_out      <= NOP_CMD;
            r_cmd_is_nop   <= 1'b1;
            r_issued_count <= 8'd0;
        end else if (datain_reg_en) begin
            if (w_pop) begin
                r_cmd_out      <= r_mem[r_rd_ptr];
                r_cmd_is_nop   <= 1'b0;
                r_issued_count <= r_issued_count + 8'd1;
            end else begin
                r_cmd_out    <= NOP_CMD;
                r_cmd_is_nop <= 1'b1;
            end
        end
    end

    // err_cmd captures the word before any same-cycle strobe reloads it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_count <= 8'd0;
            r_err_cmd   <= 7'd0;
        end else if (invalid_data) begin
            r_err_cmd <= r_cmd_out;
            if (r_err_count != 8'hFF) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign host_ready   = w_ready;
    assign cmd_out      = r_cmd_out;
    assign cmd_is_nop   = r_cmd_is_nop;
    assign level        = r_level;
    assign issued_count = r_issued_count;
    assign err_count    = r_err_count;
    assign err_cmd      = r_err_cmd;
    assign halted       = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmd_issuer
// Description : Self-checking bench for cmd_issuer against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_issuer;

    localparam int         DEPTH   = 4;
    localparam logic [6:0] NOP_CMD = 7'b0000111;

    logic       clk;
    logic       rst;
    logic [6:0] host_cmd;
    logic       host_valid;
    logic       host_ready;
    logic       datain_reg_en;
    logic       invalid_data;
    logic       halt_on_err;
    logic       resume;
    logic [6:0] cmd_out;
    logic       cmd_is_nop;
    logic [2:0] level;
    logic [7:0] issued_count;
    logic [7:0] err_count;
    logic [6:0] err_cmd;
    logic       halted;

    int n_checks;
    int n_fail;

    // Reference state
    logic [6:0] m_q[$];
    logic [6:0] m_cmd;
    logic       m_nop;
    int         m_issued;
    int         m_errs;
    logic [6:0] m_err_cmd;
    logic       m_halted;

    cmd_issuer #(.DEPTH(DEPTH), .NOP_CMD(NOP_CMD)) dut (
        .clk          (clk),
        .rst          (rst),
        .host_cmd     (host_cmd),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .datain_reg_en(datain_reg_en),
        .invalid_data (invalid_data),
        .halt_on_err  (halt_on_err),
        .resume       (resume),
        .cmd_out      (cmd_out),
        .cmd_is_nop   (cmd_is_nop),
        .level        (level),
        .issued_count (issued_count),
        .err_count    (err_count),
        .err_cmd      (err_cmd),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cmd     = NOP_CMD;
        m_nop     = 1'b1;
        m_issued  = 0;
        m_errs    = 0;
        m_err_cmd = 7'd0;
        m_halted  = 1'b0;
    endtask

    // One clock edge of behaviour, expressed on the queue directly.
    task automatic model_update();
        bit can_push;
        bit can_pop;
        can_push = host_valid && (m_q.size() != DEPTH);
        can_pop  = datain_reg_en && !m_halted && (m_q.size() > 0);
        if (invalid_data) begin
            m_err_cmd = m_cmd;
            if (m_errs < 255) m_errs++;
        end
        if (datain_reg_en) begin
            if (can_pop) begin
                m_cmd = m_q.pop_front();
                m_nop = 1'b0;
                m_issued = (m_issued + 1) % 256;
            end else begin
                m_cmd = NOP_CMD;
                m_nop = 1'b1;
            end
        end
        if (can_push) m_q.push_back(host_cmd);
        if (invalid_data && halt_on_err) m_halted = 1'b1;
        else if (resume)                 m_halted = 1'b0;
    endtask

    task automatic compare();
        chk("cmd_out",      32'(cmd_out),      32'(m_cmd));
        chk("cmd_is_nop",   32'(cmd_is_nop),   32'(m_nop));
        chk("level",        32'(level),        32'(m_q.size()));
        chk("host_ready",   32'(host_ready),   32'(m_q.size() != DEPTH));
        chk("issued_count", 32'(issued_count), 32'(m_issued));
        chk("err_count",    32'(err_count),    32'(m_errs));
        chk("err_cmd",      32'(err_cmd),      32'(m_err_cmd));
        chk("halted",       32'(halted),       32'(m_halted));
    endtask

    task automatic drive(input logic v, input logic [6:0] c, input logic s,
                         input logic inv, input logic res);
        host_valid    = v;
        host_cmd      = c;
        datain_reg_en = s;
        invalid_data  = inv;
        resume        = res;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare();
    endtask

    logic [6:0] seen[$];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst         = 1'b0;
        halt_on_err = 1'b0;
        drive(1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare();
        @(negedge clk);
        rst = 1'b1;

        // Strobes with nothing queued give filler
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
            step();
            chk("idle_nop_word", 32'(cmd_out), 32'(NOP_CMD));
            chk("idle_nop_flag", 32'(cmd_is_nop), 32'd1);
        end
        chk("idle_issued", 32'(issued_count), 32'd0);

        // Three pushes, then a strobe every 4th cycle
        drive(1'b1, 7'h21, 1'b0, 1'b0, 1'b0); step();
        drive(1'b1, 7'h42, 1'b0, 1'b0, 1'b0); step();
        drive(1'b1, 7'h63, 1'b0, 1'b0, 1'b0); step();
        seen.delete();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 7'd0, (i % 4) == 0, 1'b0, 1'b0);
            step();
            if ((i % 4) == 0) seen.push_back(cmd_out);
        end
        chk("seq_len", 32'(seen.size()), 32'd4);
        if (seen.size() == 4) begin
            chk("seq0", 32'(seen[0]), 32'h21);
            chk("seq1", 32'(seen[1]), 32'h42);
            chk("seq2", 32'(seen[2]), 32'h63);
            chk("seq3", 32'(seen[3]), 32'(NOP_CMD));
        end
        chk("seq_issued", 32'(issued_count), 32'd3);

        // Fill to capacity, overflow push ignored
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 7'(7'h30 + i), 1'b0, 1'b0, 1'b0);
            step();
        end
        chk("full_ready", 32'(host_ready), 32'd0);
        drive(1'b1, 7'h7E, 1'b0, 1'b0, 1'b0); step();
        chk("full_level", 32'(level), 32'd4);
        drive(1'b0, 7'd0, 1'b1, 1'b0, 1'b0); step();
        chk("full_pop", 32'(cmd_out), 32'h30);
        // Steady push+pop across pointer wrap
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 7'(7'h50 + i), 1'b1, 1'b0, 1'b0);
            step();
            chk("pp_level", 32'(level), 32'd3);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
            step();
        end
        chk("drained", 32'(level), 32'd0);

        // Push into empty FIFO with a same-cycle strobe: no bypass
        drive(1'b1, 7'h33, 1'b1, 1'b0, 1'b0); step();
        chk("nobypass_word", 32'(cmd_out), 32'(NOP_CMD));
        chk("nobypass_level", 32'(level), 32'd1);
        drive(1'b0, 7'd0, 1'b1, 1'b0, 1'b0); step();
        chk("nobypass_next", 32'(cmd_out), 32'h33);

        // Halt on error, strobes give NOP, resume pops the head
        halt_on_err = 1'b1;
        drive(1'b1, 7'h78, 1'b0, 1'b0, 1'b0); step();
        drive(1'b1, 7'h11, 1'b1, 1'b0, 1'b0); step();
        chk("halt_setup", 32'(cmd_out), 32'h78);
        drive(1'b0, 7'd0, 1'b0, 1'b1, 1'b0); step();
        chk("halt_err_cmd", 32'(err_cmd), 32'h78);
        chk("halt_err_cnt", 32'(err_count), 32'd1);
        chk("halt_flag", 32'(halted), 32'd1);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 7'd0, 1'b1, 1'b0, 1'b0); step();
            chk("halt_nop", 32'(cmd_out), 32'(NOP_CMD));
            chk("halt_level", 32'(level), 32'd1);
        end
        drive(1'b0, 7'd0, 1'b0, 1'b0, 1'b1); step();
        chk("resume_flag", 32'(halted), 32'd0);
        drive(1'b0, 7'd0, 1'b1, 1'b0, 1'b0); step();
        chk("resume_pop", 32'(cmd_out), 32'h11);

        // Error counter saturation
        halt_on_err = 1'b0;
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 7'd0, 1'b0, 1'b1, 1'b0);
            step();
        end
        chk("err_sat", 32'(err_count), 32'd255);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            halt_on_err = 1'($urandom_range(0, 1));
            drive(1'($urandom_range(0, 1)), 7'($urandom),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 7) == 0));
            step();
        end

        // Asynchronous reset with two entries queued
        halt_on_err = 1'b0;
        drive(1'b0, 7'd0, 1'b0, 1'b0, 1'b1); step();
        drive(1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
        while (m_q.size() > 0) step();
        drive(1'b1, 7'h2A, 1'b1, 1'b0, 1'b0); step();
        drive(1'b1, 7'h2B, 1'b0, 1'b0, 1'b0); step();
        drive(1'b0, 7'd0, 1'b1, 1'b1, 1'b0); step();
        drive(1'b1, 7'h2C, 1'b0, 1'b0, 1'b0); step();
        chk("pre_rst_level", 32'(level), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare();
        chk("rst_level", 32'(level), 32'd0);
        drive(1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 7'd0, 1'b1, 1'b0, 1'b0); step();
        chk("post_rst_nop", 32'(cmd_out), 32'(NOP_CMD));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
